// File: rtl/regbank_pkg.sv
// Shared types and defaults for the register-bank write arbiter.
package regbank_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE_A = 2'd1,
    WRITE_B = 2'd2
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Register 0 may be hard-wired: the write is accepted but never reaches the bank.
  function automatic logic write_allowed(input logic zero_ro, input logic addr_is_zero);
    return !(zero_ro && addr_is_zero);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; purely combinational.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       en,
  output logic [1:0] gnt
);

  // last: 0 = requester 0 won most recently, 1 = requester 1 did.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt = last ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Arbitrates the single register-bank write port between ALU writeback (A) and memory load (B).
module regbank_write_arbiter
  import regbank_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int AW      = AW_DEF,
  parameter bit ZERO_RO = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] data_a,
  output logic          gnt_a,
  input  logic          req_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] data_b,
  output logic          gnt_b,
  input  logic          bank_busy,
  output logic [DW-1:0] mux_a,
  output logic [DW-1:0] mux_b,
  output logic          mux_sel,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          conflict,
  output state_t        state
);

  // Handshake: a requester raises req with addr/data valid and keeps all three
  // stable until it sees gnt in the same cycle; req&gnt at a rising edge is the
  // transfer, and the captured write is presented to the bank the next cycle.
  logic       last_b;
  logic [1:0] gnt;

  rr_arbiter2 u_arb (
    .req  ({req_b, req_a}),
    .last (last_b),
    .en   (!bank_busy && !reset),
    .gnt  (gnt)
  );

  assign gnt_a = gnt[0];
  assign gnt_b = gnt[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last_b   <= 1'b1;
      mux_a    <= '0;
      mux_b    <= '0;
      mux_sel  <= SEL_A;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      conflict <= 1'b0;
    end else begin
      conflict <= req_a && req_b && !bank_busy;
      if (gnt[0]) begin
        state   <= WRITE_A;
        last_b  <= 1'b0;
        mux_a   <= data_a;
        mux_sel <= SEL_A;
        wr_addr <= addr_a;
        wr_en   <= write_allowed(ZERO_RO, addr_a == '0);
      end else if (gnt[1]) begin
        state   <= WRITE_B;
        last_b  <= 1'b1;
        mux_b   <= data_b;
        mux_sel <= SEL_B;
        wr_addr <= addr_b;
        wr_en   <= write_allowed(ZERO_RO, addr_b == '0);
      end else begin
        // Select, address and captured data hold so the bank bus stays quiet.
        state <= IDLE;
        wr_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed plus randomized bench for regbank_write_arbiter with a queued expectation model.
module tb_regbank_write_arbiter;
  import regbank_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct packed {
    logic          wr_en;
    logic [AW-1:0] addr;
    logic          sel;
    logic [DW-1:0] ma;
    logic [DW-1:0] mb;
    logic          conflict;
    logic [1:0]    st;
  } exp_t;
  localparam int EW = $bits(exp_t);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_a = 1'b0, req_b = 1'b0, bank_busy = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] data_a = '0, data_b = '0;
  logic          gnt_a, gnt_b, mux_sel, wr_en, conflict;
  logic [DW-1:0] mux_a, mux_b;
  logic [AW-1:0] wr_addr;
  state_t        state;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q[$];

  // Reference model state
  logic          m_last;
  logic [AW-1:0] m_addr;
  logic          m_sel;
  logic [DW-1:0] m_ma, m_mb;

  regbank_write_arbiter #(.DW(DW), .AW(AW), .ZERO_RO(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .addr_a(addr_a), .data_a(data_a), .gnt_a(gnt_a),
    .req_b(req_b), .addr_b(addr_b), .data_b(data_b), .gnt_b(gnt_b),
    .bank_busy(bank_busy),
    .mux_a(mux_a), .mux_b(mux_b), .mux_sel(mux_sel),
    .wr_en(wr_en), .wr_addr(wr_addr), .conflict(conflict), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_last = 1'b1;
    m_addr = '0;
    m_sel  = SEL_A;
    m_ma   = '0;
    m_mb   = '0;
    exp_q.delete();
  endtask

  // Entered at posedge+1: drive inputs, check grants mid-cycle, check registered result after the edge.
  task automatic step(input logic ra, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                      input logic rb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                      input logic busy);
    logic eg_a, eg_b;
    exp_t e, got;
    req_a = ra; addr_a = aa; data_a = da;
    req_b = rb; addr_b = ab; data_b = db;
    bank_busy = busy;
    eg_a = 1'b0;
    eg_b = 1'b0;
    if (!busy) begin
      if (ra && rb) begin
        eg_a = m_last;
        eg_b = !m_last;
      end else begin
        eg_a = ra;
        eg_b = rb;
      end
    end
    e.conflict = ra && rb && !busy;
    e.wr_en = 1'b0;
    e.st = 2'(IDLE);
    if (eg_a) begin
      m_last = 1'b0; m_addr = aa; m_sel = SEL_A; m_ma = da;
      e.wr_en = (aa != '0);
      e.st = 2'(WRITE_A);
    end else if (eg_b) begin
      m_last = 1'b1; m_addr = ab; m_sel = SEL_B; m_mb = db;
      e.wr_en = (ab != '0);
      e.st = 2'(WRITE_B);
    end
    e.addr = m_addr; e.sel = m_sel; e.ma = m_ma; e.mb = m_mb;
    exp_q.push_back(e);
    #4;
    check("gnt_a", 32'(gnt_a), 32'(eg_a));
    check("gnt_b", 32'(gnt_b), 32'(eg_b));
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check("wr_en", 32'(wr_en), 32'(got.wr_en));
    check("wr_addr", 32'(wr_addr), 32'(got.addr));
    check("mux_sel", 32'(mux_sel), 32'(got.sel));
    check("mux_a", mux_a, got.ma);
    check("mux_b", mux_b, got.mb);
    check("conflict", 32'(conflict), 32'(got.conflict));
    check("state", 32'(state), 32'(got.st));
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  // Three cycles of reset with A requesting; ends at posedge+1 with reset released.
  task automatic reset_dut();
    @(posedge clk);
    #1;
    reset = 1'b1;
    req_a = 1'b1; addr_a = 5'd4; data_a = 32'h1234_5678;
    req_b = 1'b0; bank_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_gnt_a", 32'(gnt_a), 32'd0);
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_mux_sel", 32'(mux_sel), 32'd0);
      check("rst_wr_addr", 32'(wr_addr), 32'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    req_a = 1'b0;
    model_reset();
    check("rst_mux_a", mux_a, 32'd0);
    check("rst_state", 32'(state), 32'(IDLE));
  endtask

  initial begin
    model_reset();

    // Reset behaviour
    reset_dut();

    // Single A write, then bus goes quiet
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0);
    idle();

    // Continuous contention from a fresh reset alternates A,B,A,B
    reset_dut();
    for (int i = 0; i < 4; i++)
      step(1'b1, 5'd3, 32'hA000_0000 + 32'(i), 1'b1, 5'd7, 32'hB000_0000 + 32'(i), 1'b0);
    idle();

    // Bank busy blocks grants for three cycles
    for (int i = 0; i < 3; i++)
      step(1'b0, '0, '0, 1'b1, 5'd12, 32'hCAFE_F00D, 1'b1);
    step(1'b0, '0, '0, 1'b1, 5'd12, 32'hCAFE_F00D, 1'b0);
    // Busy during the presented write does not abort it
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);

    // Write to register 0 is granted but suppressed
    step(1'b1, 5'd0, 32'h1, 1'b0, '0, '0, 1'b0);
    idle();

    // Same address from both: both land, loser one cycle later
    step(1'b1, 5'd9, 32'h1111_1111, 1'b1, 5'd9, 32'h2222_2222, 1'b0);
    step(1'b1, 5'd9, 32'h1111_1111, 1'b1, 5'd9, 32'h2222_2222, 1'b0);
    idle();

    // Randomized traffic
    for (int i = 0; i < 30; i++)
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
           ($urandom_range(0, 3) == 0));

    // Async reset in the middle of a B write
    step(1'b0, '0, '0, 1'b1, 5'd21, 32'h5555_AAAA, 1'b0);
    req_b = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("async_wr_en", 32'(wr_en), 32'd0);
    check("async_mux_sel", 32'(mux_sel), 32'd0);
    check("async_state", 32'(state), 32'(IDLE));
    #2;
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    idle();
    idle();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
